// File: rtl/game_flow_ctrl_pkg.sv
// game_flow_ctrl_pkg: shared state encodings (also the screen mux select), default timing constants, per-state entry seconds
package game_flow_ctrl_pkg;
  localparam logic [1:0] ST_START = 2'd0, ST_COUNTDOWN = 2'd1, ST_PLAY = 2'd2, ST_OVER = 2'd3;
  localparam int DEF_CLKS_PER_SEC = 25000000;
  localparam int DEF_COUNT_SECS = 3;
  localparam int DEF_PLAY_SECS = 60;
  localparam int DEF_OVER_SECS = 5;
  function automatic logic [6:0] entry_secs(logic [1:0] s, int c, int p, int o);
    return s == ST_COUNTDOWN ? 7'(c) : s == ST_PLAY ? 7'(p) : s == ST_OVER ? 7'(o) : 7'd0;
  endfunction
endpackage

// File: rtl/game_flow_ctrl_if.sv
// game_flow_ctrl_if: key_space in; screen_sel, game_active, score_clr, round_done, secs_left out (ctrl = controller side, tb = environment side)
interface game_flow_ctrl_if;
  logic       key_space;
  logic [1:0] screen_sel;
  logic       game_active;
  logic       score_clr;
  logic       round_done;
  logic [6:0] secs_left;
  modport ctrl (input key_space, output screen_sel, game_active, score_clr, round_done, secs_left);
  modport tb (output key_space, input screen_sel, game_active, score_clr, round_done, secs_left);
endinterface

// File: rtl/game_flow_ctrl_sec_prescaler.sv
// sec_prescaler: counts 0..CLKS_PER_SEC-1 (clk, async reset, clear restarts at 0), sec_tick high while at the last count
module sec_prescaler
  import game_flow_ctrl_pkg::*;
#(
  parameter int CLKS_PER_SEC = DEF_CLKS_PER_SEC
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic sec_tick
);
  localparam int W = CLKS_PER_SEC > 1 ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_SEC - 1);
  logic [W-1:0] cnt;
  assign sec_tick = cnt == LAST;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (clear || sec_tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: START/COUNTDOWN/PLAY/OVER sequencer (clk, async reset, bus: key_space in; screen_sel, game_active, score_clr, round_done, secs_left out)
module game_flow_ctrl
  import game_flow_ctrl_pkg::*;
#(
  parameter int CLKS_PER_SEC = DEF_CLKS_PER_SEC,
  parameter int COUNT_SECS = DEF_COUNT_SECS,
  parameter int PLAY_SECS = DEF_PLAY_SECS,
  parameter int OVER_SECS = DEF_OVER_SECS
) (
  input logic clk,
  input logic reset,
  game_flow_ctrl_if.ctrl bus
);
  logic [1:0] state, nxt;
  logic key_prev, press, sec_tick, expire, moved;
  assign press = bus.key_space & ~key_prev;
  assign expire = sec_tick && state != ST_START && bus.secs_left == 7'd1;
  // a press in OVER outranks a simultaneous expiry
  always_comb begin
    nxt = (state == ST_START && press) ? ST_COUNTDOWN :
          (state == ST_COUNTDOWN && expire) ? ST_PLAY :
          (state == ST_PLAY && expire) ? ST_OVER :
          (state == ST_OVER && press) ? ST_COUNTDOWN :
          (state == ST_OVER && expire) ? ST_START : state;
    moved = nxt != state;
  end
  sec_prescaler #(.CLKS_PER_SEC(CLKS_PER_SEC)) u_pre (
    .clk(clk), .reset(reset), .clear(moved), .sec_tick(sec_tick)
  );
  assign bus.screen_sel = state;
  // key_prev resets high so a key held across reset release is not a press
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_START;
      key_prev <= 1'b1;
      bus.game_active <= 1'b0;
      bus.score_clr <= 1'b0;
      bus.round_done <= 1'b0;
      bus.secs_left <= 7'd0;
    end else begin
      state <= nxt;
      key_prev <= bus.key_space;
      bus.game_active <= nxt == ST_PLAY;
      bus.score_clr <= moved && nxt == ST_COUNTDOWN;
      bus.round_done <= moved && nxt == ST_OVER;
      bus.secs_left <= moved ? entry_secs(nxt, COUNT_SECS, PLAY_SECS, OVER_SECS) :
                       (sec_tick && state != ST_START) ? bus.secs_left - 7'd1 : bus.secs_left;
    end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: scoreboard bench for game_flow_ctrl with 4 clocks per second, 3/2/5 second states
module tb_game_flow_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [11:0] q[$];
  logic [11:0] got, e;
  game_flow_ctrl_if bus();
  game_flow_ctrl #(.CLKS_PER_SEC(4), .COUNT_SECS(3), .PLAY_SECS(2), .OVER_SECS(5)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  wire [11:0] snap = {bus.screen_sel, bus.game_active, bus.score_clr, bus.round_done, bus.secs_left};

  function automatic logic [11:0] ex(logic [1:0] s, logic ga, logic sc, logic rd, logic [6:0] secs);
    return {s, ga, sc, rd, secs};
  endfunction

  task automatic test_reset();
    bus.key_space = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    q.push_back(ex(0, 0, 0, 0, 0));
    got = snap; e = q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_hold: got %h expected %h", got, e); end
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) bus.key_space = 1'b0;
      q.push_back(ex(0, 0, 0, 0, 0));
      @(posedge clk); #1;
      got = snap; e = q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset_key_held cycle %0d: got %h expected %h", i, got, e); end
    end
  endtask

  task automatic test_start();
    bus.key_space = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      q.push_back(k == 13 ? ex(2, 1, 0, 0, 2) : ex(1, 0, k == 1, 0, 7'(3 - (k - 1) / 4)));
      @(posedge clk); #1;
      if (k == 1) bus.key_space = 1'b0;
      got = snap; e = q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL start edge %0d: got %h expected %h", k, got, e); end
    end
  endtask

  task automatic test_full_round();
    for (int j = 1; j <= 8; j++) begin
      q.push_back(j == 8 ? ex(3, 0, 0, 1, 5) : ex(2, 1, 0, 0, j < 4 ? 7'd2 : 7'd1));
      @(posedge clk); #1;
      got = snap; e = q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL play edge %0d: got %h expected %h", j, got, e); end
    end
  endtask

  task automatic test_over_timeout();
    for (int j = 1; j <= 21; j++) begin
      q.push_back(j >= 20 ? ex(0, 0, 0, 0, 0) : ex(3, 0, 0, 0, 7'(5 - j / 4)));
      @(posedge clk); #1;
      got = snap; e = q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL over edge %0d: got %h expected %h", j, got, e); end
    end
  endtask

  task automatic test_restart_at_expiry();
    bus.key_space = 1'b1;
    q.push_back(ex(1, 0, 1, 0, 3));
    @(posedge clk); #1;
    bus.key_space = 1'b0;
    got = snap; e = q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL restart_start: got %h expected %h", got, e); end
    repeat (38) @(posedge clk);
    q.push_back(ex(3, 0, 0, 0, 1));
    @(posedge clk); #1;
    got = snap; e = q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL restart_last_over: got %h expected %h", got, e); end
    bus.key_space = 1'b1;
    q.push_back(ex(1, 0, 1, 0, 3));
    q.push_back(ex(1, 0, 0, 0, 3));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      bus.key_space = 1'b0;
      got = snap; e = q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL restart_press_expiry %0d: got %h expected %h", i, got, e); end
    end
  endtask

  task automatic test_ignored_and_reset();
    for (int j = 2; j <= 17; j++) begin
      bus.key_space = ((j / 3) % 2) == 1;
      q.push_back(j < 12 ? ex(1, 0, 0, 0, 7'(3 - j / 4)) : ex(2, 1, 0, 0, j < 16 ? 7'd2 : 7'd1));
      @(posedge clk); #1;
      got = snap; e = q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL ignored edge %0d: got %h expected %h", j, got, e); end
    end
    #2 reset = 1'b1;
    #1;
    q.push_back(ex(0, 0, 0, 0, 0));
    got = snap; e = q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL midplay_reset_async: got %h expected %h", got, e); end
    for (int i = 0; i < 5; i++) begin
      q.push_back(ex(0, 0, 0, 0, 0));
      @(posedge clk); #1;
      if (i == 1) begin reset = 1'b0; bus.key_space = 1'b0; end
      got = snap; e = q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL midplay_reset_after %0d: got %h expected %h", i, got, e); end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_full_round();
    test_over_timeout();
    test_restart_at_expiry();
    test_ignored_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
